// File: rtl/temp_filter_pkg.sv
// Shared types and constants for the temperature filter: sample type, alarm
// FSM state encoding and default thresholds.
package temp_filter_pkg;

    typedef logic [7:0] temp_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        NORMAL = 2'd1,
        ALARM  = 2'd2
    } filt_state_t;

    localparam temp_t TEMP_MIN      = 8'h00;
    localparam temp_t TEMP_MAX      = 8'hFF;
    localparam temp_t HI_THRESH_DEF = 8'd80;
    localparam temp_t LO_THRESH_DEF = 8'd70;

endpackage

// File: rtl/temp_ring.sv
// Circular sample buffer of 2^DEPTH_LOG2 entries with a saturating fill count.
// oldest is the entry that the next write overwrites.
module temp_ring
    import temp_filter_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  temp_t wr_data,
    output temp_t oldest,
    output logic  full,
    output logic  last_free
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    temp_t                 mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;

    // Contents are never read before being written once the ring is full,
    // so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    assign oldest    = mem[wr_ptr];
    assign full      = (count == DEPTH_CNT);
    assign last_free = (count == DEPTH_CNT - 1'b1);

endmodule

// File: rtl/temp_filter.sv
// Moving-average temperature filter with running min/max and a hysteretic
// over-temperature alarm. All outputs are registered on the sample edge.
module temp_filter
    import temp_filter_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 3,
    parameter temp_t HI_THRESH  = HI_THRESH_DEF,
    parameter temp_t LO_THRESH  = LO_THRESH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  temp_t       temp,
    input  logic        clear_minmax,
    output temp_t       avg,
    output logic        avg_valid,
    output logic        warm,
    output temp_t       min_temp,
    output temp_t       max_temp,
    output logic        alarm,
    output filt_state_t state
);

    localparam int SW = 8 + DEPTH_LOG2;

    temp_t         oldest;
    logic          full;
    logic          last_free;
    logic          fills;
    logic [SW-1:0] sum;
    logic [SW-1:0] evicted;
    logic [SW-1:0] sum_next;
    temp_t         new_avg;

    temp_ring #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tick),
        .wr_data  (temp),
        .oldest   (oldest),
        .full     (full),
        .last_free(last_free)
    );

    // A tick produces an average once the window is full, including the tick
    // that completes it.
    assign fills    = full | last_free;
    assign evicted  = full ? SW'(oldest) : '0;
    assign sum_next = sum + SW'(temp) - evicted;
    assign new_avg  = temp_t'(sum_next >> DEPTH_LOG2);
    assign warm     = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
            state     <= FILL;
            alarm     <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (tick) begin
                sum <= sum_next;
                if (fills) begin
                    avg       <= new_avg;
                    avg_valid <= 1'b1;
                end
                case (state)
                    FILL: begin
                        if (fills) begin
                            if (new_avg >= HI_THRESH) begin
                                state <= ALARM;
                                alarm <= 1'b1;
                            end else begin
                                state <= NORMAL;
                                alarm <= 1'b0;
                            end
                        end
                    end
                    NORMAL: begin
                        if (new_avg >= HI_THRESH) begin
                            state <= ALARM;
                            alarm <= 1'b1;
                        end
                    end
                    ALARM: begin
                        if (new_avg <= LO_THRESH) begin
                            state <= NORMAL;
                            alarm <= 1'b0;
                        end
                    end
                    default: begin
                        state <= FILL;
                        alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clear with a simultaneous sample restarts tracking from that sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_temp <= TEMP_MAX;
            max_temp <= TEMP_MIN;
        end else if (clear_minmax) begin
            min_temp <= tick ? temp : TEMP_MAX;
            max_temp <= tick ? temp : TEMP_MIN;
        end else if (tick) begin
            if (temp < min_temp) min_temp <= temp;
            if (temp > max_temp) max_temp <= temp;
        end
    end

endmodule

// File: doc/temp_filter.md
Name: temp_filter

Overview:
- Sits between temp_sensor and tmod_slave. Consumes the sensor's tick/temp sample stream.
- Produces a moving average over the last 2^DEPTH_LOG2 samples, running min/max, and an over-temperature alarm with hysteresis.
- tmod_slave reads the filtered values instead of raw samples, so bus reads see a stable, debounced temperature.

Parameters:
- DEPTH_LOG2, 3: log2 of window length (window = 8 samples); legal 1..5.
- HI_THRESH, 8'd80: alarm asserts when the average is at or above this value.
- LO_THRESH, 8'd70: alarm deasserts when the average is at or below this value; must be < HI_THRESH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle sample strobe from temp_sensor.
- temp  in  8  unsigned sample; valid when tick=1.
- clear_minmax  in  1  one-cycle request to restart min/max tracking.
- avg  out  8  windowed average (floor).
- avg_valid  out  1  one-cycle pulse when avg updates.
- warm  out  1  window full; avg is meaningful.
- min_temp  out  8  lowest sample since reset/clear.
- max_temp  out  8  highest sample since reset/clear.
- alarm  out  1  over-temperature flag.

Behaviour:
- Reset (async, any time, including mid-fill or during alarm):
  - All state clears immediately: avg=0, avg_valid=0, warm=0, alarm=0, min_temp=8'hFF, max_temp=8'h00.
  - Write pointer=0, fill count=0, sum=0, FSM=FILL.
- Each tick=1 cycle is one sample. Back-to-back ticks are each accepted. Inputs are ignored when tick=0.
- Storage: ring of 2^DEPTH_LOG2 x 8 bits.
  - On a tick, the sample is written at wr_ptr; wr_ptr increments modulo depth (wraps naturally).
- Running sum is 8+DEPTH_LOG2 bits wide and never overflows.
  - On a tick: sum_next = sum + temp - evicted.
  - evicted = ring[wr_ptr] when warm=1, otherwise 0.
- Fill count saturates at depth. warm sets at the edge that accepts the depth-th sample and stays set until reset.
- Average:
  - avg = sum_next >> DEPTH_LOG2, registered at the tick edge.
  - Latency: avg/avg_valid are visible the cycle after the tick is sampled.
  - avg_valid pulses for exactly one cycle per tick, and only while warm=1 (including the filling tick).
  - During FILL, avg holds 0 and avg_valid=0.
- Min/max:
  - Updated at the tick edge: min_temp = min(min_temp, temp); max_temp = max(max_temp, temp). Equal values cause no change.
  - clear_minmax without tick: min=FF, max=00.
  - clear_minmax together with tick: min=max=temp of that sample. Clear wins over the old history.
- Alarm FSM (state enum):
  - FILL -> NORMAL on the filling tick when new avg < HI_THRESH.
  - FILL -> ALARM on the filling tick when new avg >= HI_THRESH.
  - NORMAL -> ALARM on an avg update with avg >= HI_THRESH.
  - ALARM -> NORMAL on an avg update with avg <= LO_THRESH.
  - Otherwise the state holds. Averages strictly between LO and HI leave the state unchanged.
  - alarm = (state==ALARM), registered and changing on the same edge as avg.
- No backpressure: the block always accepts samples. Sensor rate is far below clock rate, but correctness must not depend on that.

Decomposition:
- Shared package defs.sv:
  - temp_t (logic [7:0]).
  - filt_state_t enum {FILL, NORMAL, ALARM}.
  - TEMP_MIN=8'h00, TEMP_MAX=8'hFF.
  - Default threshold constants.
- One sub-module: temp_ring.
  - Parameterised circular buffer with write pointer.
  - Combinational read of the oldest entry and a full flag.
- temp_filter holds the sum, min/max, and FSM.

Test Plan:
- Reset, then 8 ticks of temp=50:
  - warm=0 and no avg_valid through the 7th tick.
  - 8th tick: next cycle avg_valid=1, avg=50, warm=1, alarm=0.
- After warm-up, ticks 50,50,50,50,50,50,50,114:
  - sum=464, avg=58.
  - A further tick of 114 gives avg=66.
  - Checks eviction and floor division.
- Fill with 90:
  - alarm=1 on the filling tick.
  - Feed 75 x8: alarm stays 1 (75 > LO).
  - Feed 60 until avg<=70: alarm=0 on that update.
  - Feed 75 again: alarm stays 0.
- Samples 40, 200, 10, 90: min_temp=10, max_temp=200.
  - clear_minmax alone: FF/00.
  - clear_minmax with tick temp=33: min=max=33.
- Reset asserted asynchronously mid-clock after 5 ticks during fill:
  - Outputs reach reset values before the next edge.
  - 8 new ticks of 20 are then needed before avg_valid; avg=20, no stale data.
- Ticks on 16 consecutive cycles with incrementing temps 0..15:
  - Every tick is counted.
  - Final avg = floor((8+...+15)/8) = 11.
  - wr_ptr wraps twice without error.
